// File: rtl/vad_capture_if.sv
// Capture controller bus: VAD/sample inputs, ring write port, segment handoff and debug.
// The controller takes the master side; the reader/testbench takes the slave side.
interface vad_capture_if #(
    parameter int unsigned ADDR_W = 15
);
    logic              sample_valid;
    logic              speech_detected;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              seg_valid;
    logic [ADDR_W-1:0] seg_start;
    logic [ADDR_W:0]   seg_len;
    logic              seg_truncated;
    logic              seg_ack;
    logic [15:0]       drop_cnt;
    logic [1:0]        state;

    modport master (
        input  sample_valid, speech_detected, seg_ack,
        output wr_en, wr_addr, seg_valid, seg_start, seg_len, seg_truncated, drop_cnt, state
    );

    modport slave (
        output sample_valid, speech_detected, seg_ack,
        input  wr_en, wr_addr, seg_valid, seg_start, seg_len, seg_truncated, drop_cnt, state
    );
endinterface

// File: rtl/vad_capture_ctrl.sv
// Audio ring-buffer sequencer: streams samples into the ring, marks VAD segments with
// pre-roll history, and freezes the ring while a finished segment waits for the reader.
module vad_capture_ctrl #(
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned BUF_DEPTH  = 24000,
    parameter int unsigned PREROLL    = 4800,
    parameter int unsigned MIN_SPEECH = 1600
) (
    input  logic          clk,
    input  logic          rst,
    vad_capture_if.master cap_io
);
    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StCapture = 2'b01,
        StHold    = 2'b10
    } state_e;

    localparam logic [ADDR_W-1:0] DepthA   = ADDR_W'(BUF_DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BUF_DEPTH - 1);
    localparam logic [ADDR_W:0]   DepthL   = (ADDR_W + 1)'(BUF_DEPTH);
    localparam logic [ADDR_W:0]   PrerollL = (ADDR_W + 1)'(PREROLL);
    localparam logic [ADDR_W:0]   MinL     = (ADDR_W + 1)'(MIN_SPEECH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   spc_q, spc_d;
    logic              prev_q;
    logic              trunc_q, trunc_d;
    logic [15:0]       drop_q, drop_d;

    logic              wr;
    logic              onset;
    logic [ADDR_W-1:0] start_calc;
    logic [ADDR_W:0]   sv_ext;

    assign wr     = cap_io.sample_valid && (state_q != StHold);
    assign onset  = cap_io.speech_detected && !prev_q;
    assign sv_ext = {{ADDR_W{1'b0}}, cap_io.sample_valid};

    // Ring depth is not a power of two, so fix up the borrow explicitly.
    always_comb begin
        start_calc = wptr_q - fill_q[ADDR_W-1:0];
        if ({1'b0, wptr_q} < fill_q) begin
            start_calc = start_calc + DepthA;
        end
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        start_d = start_q;
        fill_d  = fill_q;
        len_d   = len_q;
        spc_d   = spc_q;
        trunc_d = trunc_q;
        drop_d  = drop_q;

        if (wr) begin
            wptr_d = (wptr_q == LastAddr) ? '0 : wptr_q + 1'b1;
            fill_d = (fill_q == PrerollL) ? fill_q : fill_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (onset) begin
                    state_d = StCapture;
                    start_d = start_calc;
                    len_d   = fill_q + sv_ext;
                    spc_d   = sv_ext;
                end
            end
            StCapture: begin
                len_d = len_q + sv_ext;
                spc_d = spc_q + sv_ext;
                // Hitting the ring depth wins over a simultaneous speech fall.
                if (len_d == DepthL) begin
                    state_d = StHold;
                    trunc_d = 1'b1;
                end else if (!cap_io.speech_detected) begin
                    state_d = (spc_d < MinL) ? StIdle : StHold;
                end
            end
            StHold: begin
                if (cap_io.sample_valid && (drop_q != 16'hFFFF)) begin
                    drop_d = drop_q + 16'd1;
                end
                if (cap_io.seg_ack) begin
                    state_d = StIdle;
                    trunc_d = 1'b0;
                    fill_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            start_q <= '0;
            fill_q  <= '0;
            len_q   <= '0;
            spc_q   <= '0;
            prev_q  <= 1'b0;
            trunc_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            start_q <= start_d;
            fill_q  <= fill_d;
            len_q   <= len_d;
            spc_q   <= spc_d;
            prev_q  <= cap_io.speech_detected;
            trunc_q <= trunc_d;
            drop_q  <= drop_d;
        end
    end

    assign cap_io.wr_en         = wr;
    assign cap_io.wr_addr       = wptr_q;
    assign cap_io.seg_valid     = (state_q == StHold);
    assign cap_io.seg_start     = start_q;
    assign cap_io.seg_len       = len_q;
    assign cap_io.seg_truncated = trunc_q;
    assign cap_io.drop_cnt      = drop_q;
    assign cap_io.state         = state_q;
endmodule

// File: tb/tb_vad_capture_ctrl.sv
// Bench for vad_capture_ctrl: directed scenarios plus random traffic, every cycle compared
// against an absolute-sample-count reference model.
module tb_vad_capture_ctrl;
    localparam int ADDR_W     = 15;
    localparam int BUF_DEPTH  = 24000;
    localparam int PREROLL    = 4800;
    localparam int MIN_SPEECH = 1600;

    logic clk = 1'b0;
    logic rst = 1'b0;

    vad_capture_if #(.ADDR_W(ADDR_W)) cap_if ();

    vad_capture_ctrl #(
        .ADDR_W    (ADDR_W),
        .BUF_DEPTH (BUF_DEPTH),
        .PREROLL   (PREROLL),
        .MIN_SPEECH(MIN_SPEECH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cap_io(cap_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Model: 0 idle, 1 capturing, 2 holding. Write position is derived from the
    // absolute count of samples written since reset.
    int m_mode, m_written, m_fill, m_start, m_len, m_spc, m_prev, m_trunc, m_drop;
    bit m_known = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit sv, input bit sp, input bit ack, input bit r);
        bit onset, written;
        if (r) begin
            m_mode = 0; m_written = 0; m_fill = 0; m_start = 0; m_len = 0;
            m_spc = 0; m_prev = 0; m_trunc = 0; m_drop = 0;
            m_known = 1'b1;
            return;
        end
        onset   = sp && (m_prev == 0);
        written = sv && (m_mode != 2);
        case (m_mode)
            0: if (onset) begin
                m_mode  = 1;
                m_start = (m_written - m_fill) % BUF_DEPTH;
                m_len   = m_fill + int'(sv);
                m_spc   = int'(sv);
            end
            1: begin
                m_len += int'(sv);
                m_spc += int'(sv);
                if (m_len == BUF_DEPTH) begin
                    m_mode  = 2;
                    m_trunc = 1;
                end else if (!sp) begin
                    m_mode = (m_spc < MIN_SPEECH) ? 0 : 2;
                end
            end
            default: begin
                if (sv && m_drop < 65535) m_drop++;
                if (ack) begin
                    m_mode  = 0;
                    m_trunc = 0;
                    m_fill  = 0;
                end
            end
        endcase
        if (written) begin
            m_written++;
            if (m_fill < PREROLL) m_fill++;
        end
        m_prev = int'(sp);
    endtask

    task automatic compare_outputs(input bit sv);
        check_eq("wr_en", 32'(cap_if.wr_en), 32'(sv && (m_mode != 2)));
        check_eq("wr_addr", 32'(cap_if.wr_addr), 32'(m_written % BUF_DEPTH));
        check_eq("seg_valid", 32'(cap_if.seg_valid), 32'(m_mode == 2));
        check_eq("seg_start", 32'(cap_if.seg_start), 32'(m_start));
        check_eq("seg_len", 32'(cap_if.seg_len), 32'(m_len));
        check_eq("seg_truncated", 32'(cap_if.seg_truncated), 32'(m_trunc));
        check_eq("drop_cnt", 32'(cap_if.drop_cnt), 32'(m_drop));
        check_eq("state", 32'(cap_if.state), 32'(m_mode));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic step(input bit sv, input bit sp, input bit ack, input bit r);
        cap_if.sample_valid    = sv;
        cap_if.speech_detected = sp;
        cap_if.seg_ack         = ack;
        rst                    = r;
        @(negedge clk);
        if (m_known) compare_outputs(sv);
        @(posedge clk);
        model_step(sv, sp, ack, r);
        #1;
    endtask

    task automatic check_zero_after_reset(input string tag);
        cap_if.sample_valid = 1'b0;
        #1;
        check_eq({tag, "_wr_en"}, 32'(cap_if.wr_en), 32'd0);
        check_eq({tag, "_wr_addr"}, 32'(cap_if.wr_addr), 32'd0);
        check_eq({tag, "_seg_valid"}, 32'(cap_if.seg_valid), 32'd0);
        check_eq({tag, "_seg_len"}, 32'(cap_if.seg_len), 32'd0);
        check_eq({tag, "_drop"}, 32'(cap_if.drop_cnt), 32'd0);
        check_eq({tag, "_state"}, 32'(cap_if.state), 32'd0);
    endtask

    initial begin
        int wrap_tbl[7];
        int sp_run;
        bit sp_lvl;
        wrap_tbl = '{23998, 23999, 0, 1, 2, 3, 4};
        cap_if.sample_valid    = 1'b0;
        cap_if.speech_detected = 1'b0;
        cap_if.seg_ack         = 1'b0;
        @(posedge clk);
        #1;
        step(0, 0, 0, 1);
        check_zero_after_reset("reset");

        // Wrap with no speech
        for (int i = 0; i < 24005; i++) begin
            if (i >= 23998) check_eq("wrap_addr", 32'(cap_if.wr_addr), 32'(wrap_tbl[i - 23998]));
            step(1, 0, 0, 0);
        end

        // Normal segment with full pre-roll
        step(0, 0, 0, 1);
        for (int i = 0; i < 10000; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        check_eq("norm_seg_valid", 32'(cap_if.seg_valid), 32'd1);
        check_eq("norm_seg_start", 32'(cap_if.seg_start), 32'd5200);
        check_eq("norm_seg_len", 32'(cap_if.seg_len), 32'd7800);
        check_eq("norm_trunc", 32'(cap_if.seg_truncated), 32'd0);
        cap_if.sample_valid = 1'b1;
        #1;
        check_eq("norm_hold_wr_en", 32'(cap_if.wr_en), 32'd0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        check_eq("norm_ack_state", 32'(cap_if.state), 32'd0);
        check_eq("norm_resume_addr", 32'(cap_if.wr_addr), 32'd13000);

        // Short burst on a warm buffer is discarded, fill keeps its pre-roll
        for (int i = 0; i < 5000; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 500; i++) step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        check_eq("short_seg_valid", 32'(cap_if.seg_valid), 32'd0);
        check_eq("short_state", 32'(cap_if.state), 32'd0);
        step(1, 1, 0, 0);
        check_eq("short_fill_len", 32'(cap_if.seg_len), 32'(PREROLL + 1));
        step(0, 0, 0, 0);

        // Early onset, then reset in the middle of a capture
        step(0, 0, 0, 1);
        for (int i = 0; i < 100; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        check_eq("early_seg_start", 32'(cap_if.seg_start), 32'd0);
        check_eq("early_seg_len", 32'(cap_if.seg_len), 32'd101);
        check_eq("early_state", 32'(cap_if.state), 32'd1);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0);
        step(0, 1, 0, 1);
        check_zero_after_reset("rst_capture");

        // Depth cap while speech stays high
        step(0, 0, 0, 0);
        for (int i = 0; i < 30000; i++) begin
            step(1, 1, 0, 0);
            if (i == 23999) begin
                check_eq("cap_state", 32'(cap_if.state), 32'd2);
                check_eq("cap_len", 32'(cap_if.seg_len), 32'(BUF_DEPTH));
                check_eq("cap_trunc", 32'(cap_if.seg_truncated), 32'd1);
            end
        end
        check_eq("cap_drop", 32'(cap_if.drop_cnt), 32'd6000);
        step(0, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        check_eq("cap_no_reonset", 32'(cap_if.state), 32'd0);
        check_eq("cap_trunc_clr", 32'(cap_if.seg_truncated), 32'd0);

        // Reset while holding
        step(1, 0, 0, 0);
        for (int i = 0; i < MIN_SPEECH; i++) step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        check_eq("hold_state", 32'(cap_if.state), 32'd2);
        step(0, 0, 0, 1);
        check_zero_after_reset("rst_hold");

        // Random traffic
        sp_lvl = 1'b0;
        sp_run = 0;
        for (int i = 0; i < 6000; i++) begin
            if (sp_run == 0) begin
                sp_lvl = ~sp_lvl;
                sp_run = $urandom_range(1, 2500);
            end
            sp_run--;
            step(($urandom_range(0, 3) != 0), sp_lvl, ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2999) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
